// File: rtl/muldiv_if.sv
// Start/busy/done handshake bundle between the control unit and the iterative
// multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             kill;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, kill, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, kill, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, fixed WIDTH-cycle iteration plus one finish cycle.
//
// state | meaning
// IDLE  | waiting for start; result holds last value
// RUN   | one product/quotient bit per cycle, WIDTH cycles
// FIN   | done pulse; result valid
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] m;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    logic             a_signed;
    logic             b_signed;
    logic             a_neg_in;
    logic             b_neg_in;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        a_signed = (bus.op == 3'b001) || (bus.op == 3'b010) ||
                   (bus.op == 3'b100) || (bus.op == 3'b110);
        b_signed = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
        a_neg_in = a_signed & bus.a[WIDTH-1];
        b_neg_in = b_signed & bus.b[WIDTH-1];
        a_mag    = a_neg_in ? -bus.a : bus.a;
        b_mag    = b_neg_in ? -bus.b : bus.b;
    end

    // One iteration: lo holds multiplier / dividend bits, m the multiplicand / divisor.
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        shl     = {hi, lo[WIDTH-1]};
        diff    = shl - {1'b0, m};
        if (op_q[2]) begin
            hi_nxt = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            hi_nxt = add_sum[WIDTH:1];
            lo_nxt = {add_sum[0], lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up on the values produced by the final iteration.
    logic               sign_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   fix;

    always_comb begin
        sign_diff = neg_a ^ neg_b;
        prod      = {hi_nxt, lo_nxt};
        prod_s    = sign_diff ? -prod : prod;
        // A zero divisor yields all-ones regardless of dividend sign.
        if (m == '0)
            quo_s = '1;
        else
            quo_s = sign_diff ? -lo_nxt : lo_nxt;
        rem_s = neg_a ? -hi_nxt : hi_nxt;
        case (op_q)
            3'b000:                 fix = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix = quo_s;
            default:                fix = rem_s;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            m        <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.kill) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        op_q   <= bus.op;
                        neg_a  <= a_neg_in;
                        neg_b  <= b_neg_in;
                        hi     <= '0;
                        lo     <= a_mag;
                        m      <= b_mag;
                    end
                end
                RUN: begin
                    if (bus.kill) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        hi  <= hi_nxt;
                        lo  <= lo_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state    <= FIN;
                            done_q   <= 1'b1;
                            result_q <= fix;
                        end
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, handshake scenarios and random
// operations against an arithmetic reference model, at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    muldiv_if #(.WIDTH(32)) bus  ();
    muldiv_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic on w-bit operands.
    function automatic logic [31:0] ref_model(int w, logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint half, mask, ua, ub, sa, sb, r;
        logic signed [127:0] pa, pb, p, psh;
        half = longint'(1) << (w - 1);
        mask = (longint'(1) << w) - 1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua >= half) ? ua - 2 * half : ua;
        sb = (ub >= half) ? ub - 2 * half : ub;
        r = 0;
        if (op[2] == 1'b0) begin
            pa = (op == 3'd1 || op == 3'd2) ? sa : ua;
            pb = (op == 3'd1) ? sb : ub;
            p = pa * pb;
            psh = (op == 3'd0) ? p : (p >>> w);
            r = longint'(psh[63:0]);
        end else begin
            case (op)
                3'd4: r = (ub == 0) ? mask : ((sa == -half && sb == -1) ? sa : sa / sb);
                3'd5: r = (ub == 0) ? mask : ua / ub;
                3'd6: r = (ub == 0) ? sa : ((sa == -half && sb == -1) ? 0 : sa % sb);
                default: r = (ub == 0) ? ua : ua % ub;
            endcase
        end
        return 32'(r & mask);
    endfunction

    // Called #1 after a rising edge with the unit idle; returns after done and
    // one more edge. lat counts edges after the accept edge until done is seen.
    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_cyc);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_cyc = bus.busy ? 1 : 0;
        lat = 0;
        while (!bus.done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) busy_cyc++;
        end
        if (!bus.done) begin
            total++; bad++;
            $display("FAIL run32_timeout op=%0d got no done, required done within 200 cycles", op);
        end
        res = bus.result;
        @(posedge clk); #1;
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int lat);
        bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        lat = 0;
        while (!bus8.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus8.done) begin
            total++; bad++;
            $display("FAIL run8_timeout op=%0d got no done, required done within 100 cycles", op);
        end
        res = bus8.result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] res;
        int lat, bc;
        total++; if (bus.busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0)  begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        rst = 1'b0;
        @(posedge clk); #1;
        run32(3'd0, 32'd7, 32'd9, res, lat, bc);
        total++; if (res !== 32'd63) begin bad++; $display("FAIL pre_reset_mul got=%h exp=%h", res, 32'd63); end
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            bad++; $display("FAIL midrun_reset got busy=%b done=%b result=%h exp 0/0/0", bus.busy, bus.done, bus.result);
        end
        @(posedge clk); #1 rst = 1'b0;
        run32(3'd5, 32'd1000, 32'd3, res, lat, bc);
        total++; if (res !== 32'd333) begin bad++; $display("FAIL post_reset_divu got=%h exp=%h", res, 32'd333); end
    endtask

    task automatic test_mul();
        logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] av  [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bv  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2};
        logic [31:0] ev  [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] res;
        int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run32(ops[i], av[i], bv[i], res, lat, bc);
            total++; if (res !== ev[i]) begin bad++; $display("FAIL mul_%0d got=%h exp=%h", i, res, ev[i]); end
            if (i == 0) begin
                // done visible after edge N+32, i.e. sampled at edge N+33
                total++; if (lat !== 32) begin bad++; $display("FAIL mul_latency got=%0d exp=32", lat); end
                total++; if (bc !== 33) begin bad++; $display("FAIL mul_busy_cycles got=%0d exp=33", bc); end
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] av  [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                 32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
        logic [31:0] bv  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ev  [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                 32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
        logic [31:0] res;
        int lat, bc;
        for (int i = 0; i < 8; i++) begin
            run32(ops[i], av[i], bv[i], res, lat, bc);
            total++; if (res !== ev[i]) begin bad++; $display("FAIL div_%0d got=%h exp=%h", i, res, ev[i]); end
        end
        run32(3'd4, 32'hFFFFFFF9, 32'd0, res, lat, bc);
        total++; if (res !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg_by_zero got=%h exp=ffffffff", res); end
        total++; if (lat !== 32) begin bad++; $display("FAIL div_by_zero_latency got=%0d exp=32", lat); end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        return $urandom;
    endfunction

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res, exp;
        int lat, bc;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(7));
            a = pick_operand();
            b = pick_operand();
            exp = ref_model(32, op, a, b);
            run32(op, a, b, res, lat, bc);
            total++; if (res !== exp) begin bad++; $display("FAIL random op=%0d a=%h b=%h got=%h exp=%h", op, a, b, res, exp); end
        end
    endtask

    task automatic test_start_during_run();
        int k;
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (k == 3) begin bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd3; end
            if (k == 8) bus.start = 1'b0;
        end
        total++; if (bus.done !== 1'b1 || bus.result !== 32'd14) begin
            bad++; $display("FAIL start_during_run got done=%b result=%h exp 1/%h", bus.done, bus.result, 32'd14);
        end
        total++; if (k !== 32) begin bad++; $display("FAIL start_during_run_latency got=%0d exp=32", k); end
        @(posedge clk); #1;
    endtask

    task automatic test_kill();
        logic [31:0] res;
        int lat, bc;
        logic saw_done;
        run32(3'd3, 32'd12, 32'd5, res, lat, bc);
        run32(3'd0, 32'd12, 32'd5, res, lat, bc);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd1000; bus.b = 32'd1000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL kill_busy got=%b exp=0", bus.busy); end
        saw_done = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bus.done) saw_done = 1'b1; end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL kill_no_done got=%b exp=0", saw_done); end
        total++; if (bus.result !== 32'd60) begin bad++; $display("FAIL kill_result_held got=%h exp=%h", bus.result, 32'd60); end
        // kill together with start in IDLE must not accept
        bus.start = 1'b1; bus.kill = 1'b1; bus.op = 3'd0; bus.a = 32'd2; bus.b = 32'd2;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.kill = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL kill_start_idle got busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int k;
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.op = 3'd7; bus.a = 32'd100; bus.b = 32'd7;
        k = 0;
        while (!bus.done && k < 200) begin @(posedge clk); #1; k++; end
        total++; if (bus.done !== 1'b1 || bus.result !== 32'hFFFFFFFE) begin
            bad++; $display("FAIL b2b_first got done=%b result=%h exp 1/fffffffe", bus.done, bus.result);
        end
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (k == 2) bus.start = 1'b0;
        end while (!bus.done && k < 200);
        bus.start = 1'b0;
        total++; if (k !== 34) begin bad++; $display("FAIL b2b_spacing got=%0d exp=34", k); end
        total++; if (bus.result !== 32'd2) begin bad++; $display("FAIL b2b_second got=%h exp=%h", bus.result, 32'd2); end
        @(posedge clk); #1;
    endtask

    task automatic test_width8();
        logic [7:0]  res;
        logic [2:0]  op;
        logic [7:0]  a, b;
        logic [31:0] exp;
        int lat;
        run8(3'd3, 8'hFF, 8'hFF, res, lat);
        total++; if (res !== 8'hFE) begin bad++; $display("FAIL w8_mulhu got=%h exp=fe", res); end
        total++; if (lat !== 8) begin bad++; $display("FAIL w8_latency got=%0d exp=8", lat); end
        run8(3'd4, 8'h80, 8'hFF, res, lat);
        total++; if (res !== 8'h80) begin bad++; $display("FAIL w8_div_ovf got=%h exp=80", res); end
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(7));
            a = 8'($urandom);
            b = ($urandom_range(4) == 0) ? 8'h00 : 8'($urandom);
            exp = ref_model(8, op, {24'h0, a}, {24'h0, b});
            run8(op, a, b, res, lat);
            total++; if ({24'h0, res} !== exp) begin
                bad++; $display("FAIL w8_random op=%0d a=%h b=%h got=%h exp=%h", op, a, b, res, exp[7:0]);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.kill = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
        bus8.start = 1'b0; bus8.kill = 1'b0; bus8.op = 3'd0; bus8.a = '0; bus8.b = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_mul();
        test_div();
        test_start_during_run();
        test_kill();
        test_back_to_back();
        test_random();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
